operand_sequencer: RTL
======================

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, width of each butterfly operand word.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles in RUN awaiting bfly_done; legal range 1..65535.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 load_btn  input  1  debounced "load next operand" button, level.
REQ-006 run_btn  input  1  debounced "start butterfly" button, level.
REQ-007 clr_btn  input  1  debounced "clear/abort" button, level.
REQ-008 sw  input  DATA_W  switch value captured as the current operand.
REQ-009 bfly_done  input  1  one-cycle completion pulse from the butterfly datapath.
REQ-010 a_re, a_im, b_re, b_im  output  DATA_W each  registered operands to the datapath.
REQ-011 bfly_start  output  1  one-cycle start pulse to the datapath.
REQ-012 state_o  output  3  current state code, for display.
REQ-013 err  output  1  high while in ERR.

Function
REQ-014 Each button input SHALL have a prev register; edge = input & ~prev; prev SHALL update every cycle.
REQ-015 States and codes: LD_ARE=0, LD_AIM=1, LD_BRE=2, LD_BIM=3, READY=4, RUN=5, DONE=6, ERR=7.
REQ-016 clr edge SHALL have top priority: from any state, next state LD_ARE, all operands cleared to 0, timeout counter cleared, bfly_start low.
REQ-017 In LD_ARE/LD_AIM/LD_BRE/LD_BIM a load edge SHALL capture sw into a_re/a_im/b_re/b_im respectively and advance one state (LD_BIM advances to READY); capture visible the cycle after the edge.
REQ-018 In load states run edges SHALL be ignored.
REQ-019 In READY a run edge SHALL enter RUN; a load edge without run edge SHALL enter LD_ARE without altering operands; run edge wins if both occur in the same cycle.
REQ-020 bfly_start SHALL be high exactly on the first cycle in RUN and low otherwise.
REQ-021 Operand registers SHALL not change while in RUN.
REQ-022 In RUN the timeout counter (16 bits, cleared on RUN entry) SHALL increment each cycle bfly_done is low; bfly_done high on any RUN cycle, including the bfly_start cycle, SHALL enter DONE.
REQ-023 If the counter reaches TIMEOUT with bfly_done low, next state SHALL be ERR; bfly_done and timeout in the same cycle resolve to DONE.
REQ-024 bfly_done outside RUN SHALL be ignored.
REQ-025 In DONE a run edge SHALL re-enter RUN with current operands; a load edge SHALL enter LD_ARE; run wins if simultaneous.
REQ-026 ERR SHALL be left only by a clr edge; load and run edges ignored.
REQ-027 state_o SHALL equal the registered state code; err SHALL equal (state==ERR), registered.

Reset
REQ-028 nReset low SHALL immediately force state LD_ARE, operands 0, bfly_start 0, err 0, state_o 0, counter 0.
REQ-029 Button prev registers SHALL reset to 1, so a button held through reset release produces no edge.
REQ-030 Reset asserted mid-RUN SHALL abort without emitting bfly_start after release.

Verification
REQ-031 Load sequence: sw=0x11,0x22,0x33,0x44 with four load pulses -> a_re=0x11,a_im=0x22,b_re=0x33,b_im=0x44, state_o=4.
REQ-032 Run: READY, run edge -> bfly_start high one cycle, state_o=5; bfly_done 3 cycles later -> state_o=6, no second start.
REQ-033 Timeout with TIMEOUT=4: run, no bfly_done -> ERR (state_o=7, err=1) after 4 RUN cycles; load/run ignored; clr -> state_o=0, operands 0.
REQ-034 Simultaneous load+run edges in READY -> RUN entered, operands unchanged; in LD_AIM run alone -> no state change.
REQ-035 load_btn held high across nReset release -> no capture; first real edge loads a_re.
REQ-036 clr edge during RUN with bfly_done same cycle -> LD_ARE, operands 0, not DONE.

Source files
------------

// File: rtl/operand_sequencer.sv
// operand_sequencer
//   Collects four butterfly operands from the switches, one per load-button
//   press, then launches the butterfly datapath and waits for it to finish,
//   falling into an error state if no completion pulse arrives in time.
//
// Ports
//   clk        system clock, rising edge
//   nReset     asynchronous active-low reset
//   load_btn   debounced level: capture sw into the next operand
//   run_btn    debounced level: start the butterfly
//   clr_btn    debounced level: abort and clear all operands
//   sw         switch value captured as the current operand
//   bfly_done  one-cycle completion pulse from the datapath
//   a_re/a_im/b_re/b_im  registered operands to the datapath
//   bfly_start one-cycle start pulse, high on the first RUN cycle
//   state_o    registered state code for display
//   err        registered, high while in ERR
module operand_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              load_btn,
    input  logic              run_btn,
    input  logic              clr_btn,
    input  logic [DATA_W-1:0] sw,
    input  logic              bfly_done,
    output logic [DATA_W-1:0] a_re,
    output logic [DATA_W-1:0] a_im,
    output logic [DATA_W-1:0] b_re,
    output logic [DATA_W-1:0] b_im,
    output logic              bfly_start,
    output logic [2:0]        state_o,
    output logic              err
);

    typedef enum logic [2:0] {
        StLdAre = 3'd0,
        StLdAim = 3'd1,
        StLdBre = 3'd2,
        StLdBim = 3'd3,
        StReady = 3'd4,
        StRun   = 3'd5,
        StDone  = 3'd6,
        StErr   = 3'd7
    } state_t;

    localparam logic [16:0] TimeoutVal = 17'(TIMEOUT);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
    logic [DATA_W-1:0] b_re_q, b_re_d, b_im_q, b_im_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [16:0]       cnt_inc;
    logic              start_q, start_d;
    logic              err_q, err_d;
    logic              load_prev_q, run_prev_q, clr_prev_q;
    logic              load_edge, run_edge, clr_edge;

    assign load_edge = load_btn & ~load_prev_q;
    assign run_edge  = run_btn & ~run_prev_q;
    assign clr_edge  = clr_btn & ~clr_prev_q;
    assign cnt_inc   = {1'b0, cnt_q} + 17'd1;

    always_comb begin
        state_d = state_q;
        a_re_d  = a_re_q;
        a_im_d  = a_im_q;
        b_re_d  = b_re_q;
        b_im_d  = b_im_q;
        cnt_d   = cnt_q;
        if (clr_edge) begin
            state_d = StLdAre;
            a_re_d  = '0;
            a_im_d  = '0;
            b_re_d  = '0;
            b_im_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StLdAre: if (load_edge) begin a_re_d = sw; state_d = StLdAim; end
                StLdAim: if (load_edge) begin a_im_d = sw; state_d = StLdBre; end
                StLdBre: if (load_edge) begin b_re_d = sw; state_d = StLdBim; end
                StLdBim: if (load_edge) begin b_im_d = sw; state_d = StReady; end
                StReady, StDone: begin
                    // Run wins over a simultaneous load.
                    if (run_edge) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else if (load_edge) begin
                        state_d = StLdAre;
                    end
                end
                StRun: begin
                    // Completion beats a timeout landing on the same cycle.
                    if (bfly_done) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_inc[15:0];
                        if (cnt_inc >= TimeoutVal) state_d = StErr;
                    end
                end
                StErr: ;
                default: state_d = StLdAre;
            endcase
        end
        // Start pulse only on the cycle RUN is entered.
        start_d = (state_d == StRun) && (state_q != StRun);
        err_d   = (state_d == StErr);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= StLdAre;
            a_re_q      <= '0;
            a_im_q      <= '0;
            b_re_q      <= '0;
            b_im_q      <= '0;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
            // Prev at 1 so a button held through reset release is not an edge.
            load_prev_q <= 1'b1;
            run_prev_q  <= 1'b1;
            clr_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_re_q      <= a_re_d;
            a_im_q      <= a_im_d;
            b_re_q      <= b_re_d;
            b_im_q      <= b_im_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            err_q       <= err_d;
            load_prev_q <= load_btn;
            run_prev_q  <= run_btn;
            clr_prev_q  <= clr_btn;
        end
    end

    assign a_re       = a_re_q;
    assign a_im       = a_im_q;
    assign b_re       = b_re_q;
    assign b_im       = b_im_q;
    assign bfly_start = start_q;
    assign state_o    = state_q;
    assign err        = err_q;

endmodule
